// File: rtl/q15_accumulator.sv
// Q16.48 product accumulator with +inf/-inf/NaN tracking and group framing.
// in_*: product beats (valid/ready); out_*: group result (valid/ready).
module q15_accumulator #(
  parameter int MAX_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_prod,
  input  logic        in_nan,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sum,
  output logic        out_nan,
  output logic [3:0]  out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [63:0] PINF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NINF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [3:0]  MAXC = 4'(MAX_TERMS);
  localparam logic signed [64:0] HI =
    65'sh0_7FFF_FFFF_FFFF_FFFE;
  localparam logic signed [64:0] LO =
    65'sh1_8000_0000_0000_0000;

  state_t      state, state_nxt;
  logic [63:0] acc, acc_nxt;
  logic        pinf, pinf_nxt;
  logic        ninf, ninf_nxt;
  logic        nan, nan_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  cnt_inc;
  logic        take;
  logic        is_pinf, is_ninf, is_fin;
  logic signed [64:0] sum;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign take      = in_valid & in_ready;
  assign cnt_inc   = cnt + 4'd1;

  assign is_pinf = !in_nan && (in_prod == PINF);
  assign is_ninf = !in_nan && (in_prod == NINF);
  assign is_fin  = !in_nan && !is_pinf && !is_ninf;

  assign sum = $signed({acc[63], acc})
             + $signed({in_prod[63], in_prod});

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    pinf_nxt  = pinf;
    ninf_nxt  = ninf;
    nan_nxt   = nan;
    cnt_nxt   = cnt;
    unique case (state)
      ACCUM: begin
        if (take) begin
          cnt_nxt = cnt_inc;
          unique case (1'b1)
            in_nan:  nan_nxt  = 1'b1;
            is_pinf: pinf_nxt = 1'b1;
            is_ninf: ninf_nxt = 1'b1;
            is_fin: begin
              if (sum > HI)
                pinf_nxt = 1'b1;
              else if (sum < LO)
                ninf_nxt = 1'b1;
              else
                acc_nxt = sum[63:0];
            end
          endcase
          // opposing infinities collapse to NaN
          if (pinf_nxt && ninf_nxt)
            nan_nxt = 1'b1;
          if (in_last || cnt_inc == MAXC)
            state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          pinf_nxt  = 1'b0;
          ninf_nxt  = 1'b0;
          nan_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      pinf  <= 1'b0;
      ninf  <= 1'b0;
      nan   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      pinf  <= pinf_nxt;
      ninf  <= ninf_nxt;
      nan   <= nan_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    out_nan = nan;
    if (nan)
      out_sum = NINF;
    else if (pinf)
      out_sum = PINF;
    else if (ninf)
      out_sum = NINF;
    else
      out_sum = acc;
  end

  assign out_count = cnt;

endmodule

// File: tb/tb_q15_accumulator.sv
// Directed self-checking bench for q15_accumulator.
// Linear stimulus; hand-computed expectations checked by assertions.
module tb_q15_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_prod;
  logic        in_nan;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_nan;
  logic [3:0]  out_count;

  int n_chk  = 0;
  int n_fail = 0;

  q15_accumulator #(.MAX_TERMS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_nan    (in_nan),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_nan   (out_nan),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] p,
                      input logic n,
                      input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_nan   = n;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_nan   = 1'b0;
    in_last  = 1'b0;
    in_prod  = '0;
  endtask

  task automatic result(input string tag,
                        input logic [63:0] s,
                        input logic n,
                        input logic [3:0] c);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_nan"}, 64'(out_nan), 64'(n));
    chk({tag, "_count"}, 64'(out_count), 64'(c));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_drain_sum"}, out_sum, 64'd0);
    chk({tag, "_drain_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_nan    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", out_sum, 64'd0);
    chk("rst_nan", 64'(out_nan), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // finite accumulation
    send(64'h0001_2000_0000_0000, 1'b0, 1'b0);
    chk("fin_mid_valid", 64'(out_valid), 64'd0);
    chk("fin_mid_count", 64'(out_count), 64'd1);
    send(64'h0008_0000_0000_0000, 1'b0, 1'b1);
    result("fin", 64'h0009_2000_0000_0000, 1'b0, 4'd2);
    drain("fin");

    // sign crossing
    send(64'h0008_0000_0000_0000, 1'b0, 1'b0);
    send(64'hFFF7_0000_0000_0000, 1'b0, 1'b1);
    result("sign", 64'hFFFF_0000_0000_0000, 1'b0, 4'd2);
    drain("sign");

    // positive overflow -> +inf
    send(64'h7FF0_0000_0000_0000, 1'b0, 1'b0);
    send(64'h0020_0000_0000_0000, 1'b0, 1'b1);
    result("povf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'd2);
    drain("povf");

    // negative overflow -> -inf
    send(64'h8001_0000_0000_0000, 1'b0, 1'b0);
    send(64'h8001_0000_0000_0000, 1'b0, 1'b1);
    result("novf", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd2);
    drain("novf");

    // +inf plus -inf -> NaN
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    result("infnan", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd2);
    drain("infnan");

    // multiplier NaN is sticky
    send(64'h0000_0000_0000_0005, 1'b1, 1'b0);
    send(64'h0001_0000_0000_0000, 1'b0, 1'b1);
    result("nanin", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd2);
    drain("nanin");

    // MAX_TERMS closes the group
    for (int i = 0; i < 7; i++)
      send(64'h0001_0000_0000_0000, 1'b0, 1'b0);
    chk("max7_ready", 64'(in_ready), 64'd1);
    chk("max7_count", 64'(out_count), 64'd7);
    send(64'h0001_0000_0000_0000, 1'b0, 1'b0);
    result("max8", 64'h0008_0000_0000_0000, 1'b0, 4'd8);
    drain("max8");

    // backpressure: beats offered in HOLD are ignored
    send(64'h0003_0000_0000_0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_prod  = 64'h0100_0000_0000_0000;
      in_nan   = 1'b1;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      result("bp", 64'h0003_0000_0000_0000, 1'b0, 4'd1);
    end
    in_valid = 1'b0;
    in_nan   = 1'b0;
    in_last  = 1'b0;
    drain("bp");

    // reset mid-group discards partial sum
    send(64'h0004_0000_0000_0000, 1'b0, 1'b0);
    send(64'h0004_0000_0000_0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_sum", out_sum, 64'd0);
    chk("mrst_nan", 64'(out_nan), 64'd0);
    chk("mrst_count", 64'(out_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'h0002_0000_0000_0000, 1'b0, 1'b1);
    result("post", 64'h0002_0000_0000_0000, 1'b0, 4'd1);
    drain("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
